// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded fields and forwarding sources in, ALU operands and controls out.
interface id_ex_if #(
    parameter int WIDTH = 64
);
    // Stage control
    logic             Stall;
    logic             Flush;
    // Decoded instruction from ID
    logic [WIDTH-1:0] RegData1;
    logic [WIDTH-1:0] RegData2;
    logic [WIDTH-1:0] ExtImm;
    logic [4:0]       Rn;
    logic [4:0]       Rm;
    logic [4:0]       Rd;
    logic [10:0]      Opcode;
    logic [1:0]       ALUOp;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemToReg;
    // Forwarding sources from later stages
    logic             EXMEM_RegWrite;
    logic [4:0]       EXMEM_Rd;
    logic [WIDTH-1:0] EXMEM_Result;
    logic             MEMWB_RegWrite;
    logic [4:0]       MEMWB_Rd;
    logic [WIDTH-1:0] MEMWB_Result;
    // Execute-side outputs
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] StoreData;
    logic [4:0]       ex_Rd;
    logic             ex_RegWrite;
    logic             ex_MemRead;
    logic             ex_MemWrite;
    logic             ex_MemToReg;
    logic             ex_valid;
    logic             LoadUseHazard;

    // Pipeline side that feeds the stage and consumes its results
    modport master (
        output Stall, Flush, RegData1, RegData2, ExtImm, Rn, Rm, Rd, Opcode, ALUOp,
               ALUSrc, RegWrite, MemRead, MemWrite, MemToReg,
               EXMEM_RegWrite, EXMEM_Rd, EXMEM_Result,
               MEMWB_RegWrite, MEMWB_Rd, MEMWB_Result,
        input  BusA, BusB, ALUCtrl, StoreData, ex_Rd, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_MemToReg, ex_valid, LoadUseHazard
    );

    // The ID/EX stage itself
    modport slave (
        input  Stall, Flush, RegData1, RegData2, ExtImm, Rn, Rm, Rd, Opcode, ALUOp,
               ALUSrc, RegWrite, MemRead, MemWrite, MemToReg,
               EXMEM_RegWrite, EXMEM_Rd, EXMEM_Result,
               MEMWB_RegWrite, MEMWB_Rd, MEMWB_Result,
        output BusA, BusB, ALUCtrl, StoreData, ex_Rd, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_MemToReg, ex_valid, LoadUseHazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM + MEM/WB operand
// forwarding and load-use bubble insertion.
module id_ex_stage #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input logic   CLK,
    input logic   Reset,
    id_ex_if.slave bus
);
    localparam logic [4:0] zeroIdx = ZERO_REG[4:0];

    // Stage contents
    logic             valid_r;
    logic [4:0]       rd_r;
    logic [4:0]       rn_r;
    logic [4:0]       rm_r;
    logic             regWrite_r;
    logic             memRead_r;
    logic             memWrite_r;
    logic             memToReg_r;
    logic             aluSrc_r;
    logic [3:0]       aluCtrl_r;
    logic [WIDTH-1:0] opA_r;
    logic [WIDTH-1:0] opB_r;
    logic [WIDTH-1:0] imm_r;

    logic [WIDTH-1:0] fwdA_s;
    logic [WIDTH-1:0] fwdB_s;
    logic             loadUse_s;
    logic             bubble_s;

    // ALU control decode; unknown R/I-format opcodes map to 1111 (ALU yields 0).
    function automatic logic [3:0] decodeAluCtrl(input logic [1:0] aluOp, input logic [10:0] opcode);
        logic [3:0] ctrl;
        case (aluOp)
            2'b00: ctrl = 4'b0010;
            2'b01: ctrl = 4'b0111;
            2'b11: ctrl = 4'b0111;
            2'b10: begin
                casez (opcode)
                    11'b10001011000: ctrl = 4'b0010;
                    11'b11001011000: ctrl = 4'b0110;
                    11'b10001010000: ctrl = 4'b0000;
                    11'b10101010000: ctrl = 4'b0001;
                    11'b1001000100?: ctrl = 4'b0010;
                    11'b1101000100?: ctrl = 4'b0110;
                    default:         ctrl = 4'b1111;
                endcase
            end
            default: ctrl = 4'b1111;
        endcase
        return ctrl;
    endfunction

    // Youngest producer wins; the zero register is never forwarded.
    function automatic logic [WIDTH-1:0] forwardOperand(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] regVal,
        input logic             exRw,
        input logic [4:0]       exRd,
        input logic [WIDTH-1:0] exRes,
        input logic             wbRw,
        input logic [4:0]       wbRd,
        input logic [WIDTH-1:0] wbRes
    );
        logic [WIDTH-1:0] val;
        if (exRw && (exRd == idx) && (idx != zeroIdx)) begin
            val = exRes;
        end else if (wbRw && (wbRd == idx) && (idx != zeroIdx)) begin
            val = wbRes;
        end else begin
            val = regVal;
        end
        return val;
    endfunction

    // Forwarding muxes and hazard/bubble decision for the coming edge
    always_comb begin
        fwdA_s = forwardOperand(rn_r, opA_r, bus.EXMEM_RegWrite, bus.EXMEM_Rd, bus.EXMEM_Result,
                                bus.MEMWB_RegWrite, bus.MEMWB_Rd, bus.MEMWB_Result);
        fwdB_s = forwardOperand(rm_r, opB_r, bus.EXMEM_RegWrite, bus.EXMEM_Rd, bus.EXMEM_Result,
                                bus.MEMWB_RegWrite, bus.MEMWB_Rd, bus.MEMWB_Result);
        if (valid_r && memRead_r && (rd_r != zeroIdx) && ((rd_r == bus.Rn) || (rd_r == bus.Rm))) begin
            loadUse_s = ~bus.Stall;
        end else begin
            loadUse_s = 1'b0;
        end
        // Reset and Flush beat Stall; the hazard term is already masked by Stall.
        bubble_s = Reset | bus.Flush | loadUse_s;
    end

    // Stage register: bubble, stall (data refresh only) or normal capture.
    // Bubbles park Rn/Rm on the zero register so forwarding cannot leak data
    // onto the operand buses of an empty stage.
    always_ff @(posedge CLK) begin
        if (bubble_s) begin
            valid_r    <= 1'b0;
            rd_r       <= 5'd0;
            rn_r       <= zeroIdx;
            rm_r       <= zeroIdx;
            regWrite_r <= 1'b0;
            memRead_r  <= 1'b0;
            memWrite_r <= 1'b0;
            memToReg_r <= 1'b0;
            aluSrc_r   <= 1'b0;
            aluCtrl_r  <= 4'b0000;
            opA_r      <= {WIDTH{1'b0}};
            opB_r      <= {WIDTH{1'b0}};
            imm_r      <= {WIDTH{1'b0}};
        end else if (bus.Stall) begin
            // Keep absorbing forwarded values so a writeback retiring now is not lost.
            opA_r <= fwdA_s;
            opB_r <= fwdB_s;
        end else begin
            valid_r    <= 1'b1;
            rd_r       <= bus.Rd;
            rn_r       <= bus.Rn;
            rm_r       <= bus.Rm;
            regWrite_r <= bus.RegWrite;
            memRead_r  <= bus.MemRead;
            memWrite_r <= bus.MemWrite;
            memToReg_r <= bus.MemToReg;
            aluSrc_r   <= bus.ALUSrc;
            aluCtrl_r  <= decodeAluCtrl(bus.ALUOp, bus.Opcode);
            opA_r      <= bus.RegData1;
            opB_r      <= bus.RegData2;
            imm_r      <= bus.ExtImm;
        end
    end

    assign bus.BusA          = fwdA_s;
    assign bus.BusB          = aluSrc_r ? imm_r : fwdB_s;
    assign bus.StoreData     = fwdB_s;
    assign bus.ALUCtrl       = aluCtrl_r;
    assign bus.ex_Rd         = rd_r;
    assign bus.ex_RegWrite   = regWrite_r;
    assign bus.ex_MemRead    = memRead_r;
    assign bus.ex_MemWrite   = memWrite_r;
    assign bus.ex_MemToReg   = memToReg_r;
    assign bus.ex_valid      = valid_r;
    assign bus.LoadUseHazard = loadUse_s;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_id_ex_stage;
    localparam int W = 64;

    logic CLK = 1'b0;
    logic Reset;

    id_ex_if #(.WIDTH(W)) bus();

    id_ex_stage #(.WIDTH(W), .ZERO_REG(31)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural view of what the stage holds
    bit          mValid;
    bit  [4:0]   mRd, mRn, mRm;
    bit          mRw, mMr, mMw, mM2r, mSrc;
    bit  [3:0]   mCtrl;
    bit  [W-1:0] mA, mB, mImm;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected ALU control from the instruction semantics
    function automatic bit [3:0] expCtrl(input bit [1:0] op, input bit [10:0] opc);
        if (op == 2'd0) return 4'd2;
        if (op[0])      return 4'd7;
        if (opc == 11'h458) return 4'd2;        // ADD
        if (opc == 11'h658) return 4'd6;        // SUB
        if (opc == 11'h450) return 4'd0;        // AND
        if (opc == 11'h550) return 4'd1;        // ORR
        if ((opc >> 1) == 11'h244) return 4'd2; // ADDI
        if ((opc >> 1) == 11'h344) return 4'd6; // SUBI
        return 4'hF;
    endfunction

    function automatic bit [W-1:0] fwd(input bit [4:0] idx, input bit [W-1:0] rv);
        if (idx == 5'd31) return rv;
        if (bus.EXMEM_RegWrite && bus.EXMEM_Rd == idx) return bus.EXMEM_Result;
        if (bus.MEMWB_RegWrite && bus.MEMWB_Rd == idx) return bus.MEMWB_Result;
        return rv;
    endfunction

    function automatic bit expHazard();
        return mValid && mMr && (mRd != 5'd31) && (mRd == bus.Rn || mRd == bus.Rm) && !bus.Stall;
    endfunction

    task automatic modelBubble();
        mValid = 1'b0; mRd = 5'd0; mRn = 5'd31; mRm = 5'd31;
        mRw = 1'b0; mMr = 1'b0; mMw = 1'b0; mM2r = 1'b0; mSrc = 1'b0;
        mCtrl = 4'd0; mA = '0; mB = '0; mImm = '0;
    endtask

    // Next-state of the model from the inputs present before the edge
    task automatic updateModel();
        bit [W-1:0] a, b;
        a = fwd(mRn, mA);
        b = fwd(mRm, mB);
        if (Reset || bus.Flush || expHazard()) begin
            modelBubble();
        end else if (bus.Stall) begin
            mA = a; mB = b;
        end else begin
            mValid = 1'b1; mRd = bus.Rd; mRn = bus.Rn; mRm = bus.Rm;
            mRw = bus.RegWrite; mMr = bus.MemRead; mMw = bus.MemWrite; mM2r = bus.MemToReg;
            mSrc = bus.ALUSrc; mCtrl = expCtrl(bus.ALUOp, bus.Opcode);
            mA = bus.RegData1; mB = bus.RegData2; mImm = bus.ExtImm;
        end
    endtask

    // The single per-cycle compare of every DUT output against the model
    task automatic compareModel();
        bit [W-1:0] b;
        b = fwd(mRm, mB);
        chk("BusA", bus.BusA, fwd(mRn, mA));
        chk("BusB", bus.BusB, mSrc ? mImm : b);
        chk("StoreData", bus.StoreData, b);
        chk("ALUCtrl", 64'(bus.ALUCtrl), 64'(mCtrl));
        chk("ex_Rd", 64'(bus.ex_Rd), 64'(mRd));
        chk("ex_ctrl", 64'({bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemToReg}),
            64'({mRw, mMr, mMw, mM2r}));
        chk("ex_valid", 64'(bus.ex_valid), 64'(mValid));
        chk("LoadUseHazard", 64'(bus.LoadUseHazard), 64'(expHazard()));
    endtask

    // One clock: compare mid-low-phase, advance model, end at the next negedge
    task automatic cycle();
        #1;
        compareModel();
        updateModel();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic bit [4:0] pickReg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    function automatic bit [10:0] pickOpcode();
        case ($urandom_range(0, 8))
            0: return 11'h458;
            1: return 11'h658;
            2: return 11'h450;
            3: return 11'h550;
            4: return 11'h488;
            5: return 11'h489;
            6: return 11'h688;
            7: return 11'h689;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic randomizeInputs();
        bus.Stall          = ($urandom_range(0, 99) < 15);
        bus.Flush          = ($urandom_range(0, 99) < 8);
        bus.RegData1       = {$urandom(), $urandom()};
        bus.RegData2       = {$urandom(), $urandom()};
        bus.ExtImm         = {$urandom(), $urandom()};
        bus.Rn             = pickReg();
        bus.Rm             = pickReg();
        bus.Rd             = pickReg();
        bus.Opcode         = pickOpcode();
        bus.ALUOp          = 2'($urandom_range(0, 3));
        bus.ALUSrc         = 1'($urandom_range(0, 1));
        bus.RegWrite       = 1'($urandom_range(0, 1));
        bus.MemRead        = 1'($urandom_range(0, 1));
        bus.MemWrite       = 1'($urandom_range(0, 1));
        bus.MemToReg       = 1'($urandom_range(0, 1));
        bus.EXMEM_RegWrite = 1'($urandom_range(0, 1));
        bus.EXMEM_Rd       = pickReg();
        bus.EXMEM_Result   = {$urandom(), $urandom()};
        bus.MEMWB_RegWrite = 1'($urandom_range(0, 1));
        bus.MEMWB_Rd       = pickReg();
        bus.MEMWB_Result   = {$urandom(), $urandom()};
    endtask

    task automatic setIdle();
        bus.Stall = 1'b0; bus.Flush = 1'b0;
        bus.RegData1 = '0; bus.RegData2 = '0; bus.ExtImm = '0;
        bus.Rn = 5'd0; bus.Rm = 5'd0; bus.Rd = 5'd0;
        bus.Opcode = 11'd0; bus.ALUOp = 2'd0;
        bus.ALUSrc = 1'b0; bus.RegWrite = 1'b0; bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0; bus.MemToReg = 1'b0;
        bus.EXMEM_RegWrite = 1'b0; bus.EXMEM_Rd = 5'd0; bus.EXMEM_Result = '0;
        bus.MEMWB_RegWrite = 1'b0; bus.MEMWB_Rd = 5'd0; bus.MEMWB_Result = '0;
    endtask

    task automatic presentAdd(input bit [4:0] rd, input bit [4:0] rn, input bit [4:0] rm,
                              input bit [W-1:0] d1, input bit [W-1:0] d2);
        bus.ALUOp = 2'b10; bus.Opcode = 11'b10001011000; bus.ALUSrc = 1'b0;
        bus.RegWrite = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.MemToReg = 1'b0;
        bus.Rd = rd; bus.Rn = rn; bus.Rm = rm; bus.RegData1 = d1; bus.RegData2 = d2;
    endtask

    initial begin
        modelBubble();
        // 1. Reset for two cycles with random inputs
        randomizeInputs();
        Reset = 1'b1;
        @(posedge CLK);
        updateModel();
        @(negedge CLK);
        randomizeInputs();
        cycle();
        chk("rst_BusA", bus.BusA, 64'd0);
        chk("rst_BusB", bus.BusB, 64'd0);
        chk("rst_StoreData", bus.StoreData, 64'd0);
        chk("rst_ALUCtrl", 64'(bus.ALUCtrl), 64'd0);
        chk("rst_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_ctrl", 64'({bus.ex_Rd, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemToReg}), 64'd0);
        Reset = 1'b0;
        setIdle();
        presentAdd(5'd1, 5'd2, 5'd3, 64'd5, 64'd7);
        cycle();
        chk("add_ALUCtrl", 64'(bus.ALUCtrl), 64'h2);
        chk("add_BusA", bus.BusA, 64'd5);
        chk("add_BusB", bus.BusB, 64'd7);

        // 2. Forwarding priority on captured Rn=2
        bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_Rd = 5'd2; bus.EXMEM_Result = 64'hAA;
        bus.MEMWB_RegWrite = 1'b1; bus.MEMWB_Rd = 5'd2; bus.MEMWB_Result = 64'hBB;
        #1 chk("fwd_exmem", bus.BusA, 64'hAA);
        bus.EXMEM_RegWrite = 1'b0;
        #1 chk("fwd_memwb", bus.BusA, 64'hBB);
        bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_Rd = 5'd31; bus.MEMWB_Rd = 5'd31;
        #1 chk("fwd_none", bus.BusA, 64'd5);
        cycle();
        bus.EXMEM_RegWrite = 1'b0; bus.MEMWB_RegWrite = 1'b0;

        // 3. Load-use: LDUR X4 then SUB with Rm=4
        bus.ALUOp = 2'b00; bus.Opcode = 11'b11111000010; bus.ALUSrc = 1'b1; bus.ExtImm = 64'd8;
        bus.RegWrite = 1'b1; bus.MemRead = 1'b1; bus.MemToReg = 1'b1; bus.Rd = 5'd4; bus.Rn = 5'd2;
        cycle();
        bus.ALUOp = 2'b10; bus.Opcode = 11'b11001011000; bus.ALUSrc = 1'b0;
        bus.MemRead = 1'b0; bus.MemToReg = 1'b0; bus.Rd = 5'd5; bus.Rn = 5'd1; bus.Rm = 5'd4;
        #1 chk("lu_hazard", 64'(bus.LoadUseHazard), 64'd1);
        cycle();
        chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("lu_bubble_ctrl", 64'({bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemToReg}), 64'd0);
        cycle();
        chk("lu_sub_ctrl", 64'(bus.ALUCtrl), 64'h6);
        chk("lu_sub_valid", 64'(bus.ex_valid), 64'd1);

        // 4. Stall with MEM/WB writeback to captured Rn
        bus.ALUOp = 2'b00; bus.Opcode = 11'b11111000010; bus.ALUSrc = 1'b1; bus.ExtImm = 64'h20;
        bus.RegWrite = 1'b1; bus.MemRead = 1'b1; bus.MemToReg = 1'b1;
        bus.Rd = 5'd6; bus.Rn = 5'd3; bus.Rm = 5'd31; bus.RegData1 = 64'h55;
        cycle();
        bus.Stall = 1'b1;
        bus.MEMWB_RegWrite = 1'b1; bus.MEMWB_Rd = 5'd3; bus.MEMWB_Result = 64'h1234;
        bus.ALUOp = 2'b10; bus.Opcode = 11'b11001011000; bus.Rd = 5'd9; bus.Rn = 5'd6;
        bus.MemRead = 1'b0; bus.RegData1 = 64'h77;
        #1 chk("stall_hazard_gated", 64'(bus.LoadUseHazard), 64'd0);
        cycle();
        chk("stall_ALUCtrl", 64'(bus.ALUCtrl), 64'h2);
        chk("stall_ex_Rd", 64'(bus.ex_Rd), 64'd6);
        cycle();
        bus.MEMWB_RegWrite = 1'b0;
        cycle();
        chk("stall_BusA_kept", bus.BusA, 64'h1234);
        chk("stall_hazard_low", 64'(bus.LoadUseHazard), 64'd0);
        chk("stall_ALUCtrl_end", 64'(bus.ALUCtrl), 64'h2);
        bus.Stall = 1'b0;
        #1 chk("unstall_hazard", 64'(bus.LoadUseHazard), 64'd1);
        cycle();

        // 5. Stall + Flush together
        setIdle();
        presentAdd(5'd1, 5'd1, 5'd2, 64'd3, 64'd4);
        cycle();
        bus.Stall = 1'b1; bus.Flush = 1'b1;
        cycle();
        chk("flush_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush_regwrite", 64'(bus.ex_RegWrite), 64'd0);
        bus.Stall = 1'b0; bus.Flush = 1'b0;

        // 6. ADDI, STUR, unknown opcode
        bus.ALUOp = 2'b10; bus.Opcode = 11'b10010001000; bus.ALUSrc = 1'b1; bus.ExtImm = 64'h10;
        bus.Rn = 5'd1; bus.Rm = 5'd2; bus.RegData1 = 64'd3; bus.RegData2 = 64'h99;
        cycle();
        chk("addi_BusB", bus.BusB, 64'h10);
        chk("addi_StoreData", bus.StoreData, 64'h99);
        chk("addi_ALUCtrl", 64'(bus.ALUCtrl), 64'h2);
        bus.ALUOp = 2'b00; bus.Opcode = 11'b11111000000; bus.MemWrite = 1'b1; bus.RegWrite = 1'b0;
        cycle();
        chk("stur_ALUCtrl", 64'(bus.ALUCtrl), 64'h2);
        bus.ALUOp = 2'b10; bus.Opcode = 11'b11111111111; bus.MemWrite = 1'b0;
        cycle();
        chk("unknown_ALUCtrl", 64'(bus.ALUCtrl), 64'hF);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            randomizeInputs();
            Reset = ($urandom_range(0, 99) < 2);
            cycle();
        end
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
